// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// blank code, all-digits-off helper and the slot state type.
package seg_pkg;

    localparam logic [3:0] SEG_BLANK_NIB = 4'hF;
    localparam int         MAX_DIGITS    = 32;

    typedef enum logic {
        DARK = 1'b0,
        SHOW = 1'b1
    } slot_state_e;

    // Active-low select with every digit switched off, LSB-aligned in a MAX_DIGITS word.
    function automatic logic [MAX_DIGITS-1:0] dig_sel_off(input int n);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: owns the in-slot counter, the digit index and the DARK/SHOW slot FSM.
// slot_dark_o and idx_o are the values for the coming cycle so the owner can register outputs.
module scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             slot_dark_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_edge_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    slot_state_e      state_q, state_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        case (state_q)
            DARK:    if (cnt_d == CNT_DEAD) state_d = SHOW;
            SHOW:    if (cnt_d == '0)       state_d = DARK;
            default: state_d = DARK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DARK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign slot_dark_o  = (state_d == DARK);
    assign idx_o        = idx_d;
    assign frame_edge_o = slot_end && (idx_q == IDX_LAST);

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// frame-synchronous double buffering, leading-zero blanking and inter-digit dark time.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic                    load,
    input  logic                    lzb_en,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int W     = 4 * NUM_DIGITS;
    localparam logic [MAX_DIGITS-1:0] OFF_ALL = dig_sel_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = OFF_ALL[NUM_DIGITS-1:0];

    logic             slot_dark;
    logic [IDX_W-1:0] idx_next;
    logic             frame_edge;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .slot_dark_o  (slot_dark),
        .idx_o        (idx_next),
        .frame_edge_o (frame_edge)
    );

    logic [W-1:0]            active_q, active_d;
    logic [W-1:0]            pend_q, pend_d;
    logic                    pend_v_q, pend_v_d;
    logic [3:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nib;
    logic                    blank_sel;

    // The displayed word only ever changes on the frame edge; a load there bypasses pend.
    always_comb begin
        active_d = active_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (frame_edge) begin
            pend_v_d = 1'b0;
            if (load)          active_d = din;
            else if (pend_v_q) active_d = pend_q;
        end else if (load) begin
            pend_d   = din;
            pend_v_d = 1'b1;
        end
    end

    always_comb begin : blank_calc
        logic zeros_above;
        zeros_above = 1'b1;
        blank       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeros_above = zeros_above && (active_d[4*k +: 4] == 4'h0);
            blank[k]    = lzb_en && zeros_above && (k != 0);
        end
    end

    always_comb begin
        nib       = active_d[3:0];
        blank_sel = blank[0];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next == IDX_W'(k)) begin
                nib       = active_d[4*k +: 4];
                blank_sel = blank[k];
            end
        end
    end

    // Outputs are computed from next-cycle timer state so the registers line up with cnt/idx.
    always_comb begin
        frame_done_d = frame_edge;
        hex_d        = SEG_BLANK_NIB;
        dig_sel_d    = DIG_OFF;
        if (!slot_dark) begin
            dig_sel_d = ~(NUM_DIGITS'(1) << idx_next);
            hex_d     = blank_sel ? SEG_BLANK_NIB : nib;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q     <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            hex_q        <= SEG_BLANK_NIB;
            dig_sel_q    <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            hex_q        <= hex_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hex        = hex_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed scenarios plus random loads, checked
// every cycle against a cycle-count based reference model of the scan display.
module tb_seg_scan;

    localparam int N = 4;
    localparam int S = 8;
    localparam int D = 2;
    localparam int F = N * S;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        load;
    logic        lzb_en;
    logic [3:0]  hex;
    logic [3:0]  dig_sel;
    logic        frame_done;

    seg_scan #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (S),
        .DEAD_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load       (load),
        .lzb_en     (lzb_en),
        .hex        (hex),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          t_m;
    logic [15:0] w_m;
    logic [15:0] pend_m;
    logic        pv_m;
    logic        lz_cur;
    logic [8:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t_m, obs, exp);
        end
    endtask

    // Expected {frame_done, dig_sel, hex} for cycle t of the scan showing word w.
    function automatic logic [8:0] model_out(input int t, input logic [15:0] w, input logic lz);
        int         pos;
        int         dg;
        logic [3:0] h;
        logic [3:0] ds;
        logic       fd;
        pos = t % S;
        dg  = (t / S) % N;
        h   = 4'hF;
        ds  = 4'hF;
        fd  = (t > 0) && (t % F == 0);
        if (pos >= D) begin
            ds = 4'hF & ~(4'b0001 << dg);
            h  = 4'((w >> (4 * dg)) & 16'h000F);
            if (lz && dg > 0 && (w >> (4 * dg)) == 16'h0000) h = 4'hF;
        end
        return {fd, ds, h};
    endfunction

    task automatic model_edge(input logic r, input logic ld, input logic [15:0] d, input logic lz);
        if (r) begin
            t_m    = 0;
            w_m    = 16'h0;
            pend_m = 16'h0;
            pv_m   = 1'b0;
        end else begin
            if (t_m % F == F - 1) begin
                if (ld)        w_m = d;
                else if (pv_m) w_m = pend_m;
                pv_m = 1'b0;
            end else if (ld) begin
                pend_m = d;
                pv_m   = 1'b1;
            end
            t_m++;
        end
        exp_q.push_back(model_out(t_m, w_m, lz));
    endtask

    task automatic step(input logic ld, input logic [15:0] d, input logic r);
        logic [8:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("hex",        16'(hex),        16'(e[3:0]));
            check_eq("dig_sel",    16'(dig_sel),    16'(e[7:4]));
            check_eq("frame_done", 16'(frame_done), 16'(e[8]));
        end
        load   = ld;
        din    = d;
        rst    = r;
        lzb_en = lz_cur;
        @(posedge clk);
        model_edge(r, ld, d, lz_cur);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 4 * F && t_m != target; i++) step(1'b0, 16'h0, 1'b0);
        check_eq("run_to", 16'(t_m), 16'(target));
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] v;
        v = 16'h0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        din    = 16'h0;
        lz_cur = 1'b0;
        lzb_en = 1'b0;
        t_m    = 0;
        w_m    = 16'h0;
        pend_m = 16'h0;
        pv_m   = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);

        // Scan order with a load in the first frame.
        run_to(10);
        step(1'b1, 16'h4321, 1'b0);
        // Mid-frame load commits only at the next boundary.
        run_to(40);
        step(1'b1, 16'h1234, 1'b0);
        // Two loads in one frame: last wins.
        run_to(70);
        step(1'b1, 16'h1111, 1'b0);
        run_to(80);
        step(1'b1, 16'h2222, 1'b0);
        // Boundary collision: load on the boundary edge beats the pending word.
        run_to(100);
        step(1'b1, 16'h9999, 1'b0);
        run_to(127);
        step(1'b1, 16'h5678, 1'b0);
        run_to(F * 6 + 3);
        // Blanking cases.
        lz_cur = 1'b1;
        step(1'b1, 16'h0070, 1'b0);
        run_to(F * 7 + 20);
        step(1'b1, 16'h0000, 1'b0);
        run_to(F * 8 + 16);
        lz_cur = 1'b0;
        run_to(F * 9 + 4);

        // Randomised loads, boundary loads and blanking toggles.
        for (int i = 0; i < 12 * F; i++) begin
            logic ld;
            if ($urandom_range(0, 39) == 0) lz_cur = ~lz_cur;
            if (t_m % F == F - 1) ld = ($urandom_range(0, 2) == 0);
            else                  ld = ($urandom_range(0, 15) == 0);
            step(ld, rand_word(), 1'b0);
        end

        // Mid-frame reset during digit 2 SHOW with a pending word.
        run_to(F * 22 + 5);
        step(1'b1, 16'hABCD, 1'b0);
        run_to(F * 22 + 20);
        lz_cur = 1'b0;
        step(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < F + 8; i++) step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
